// File: rtl/cpu_isa_pkg.sv
// Instruction-set constants for the Tetris CPU controller: ALU ops, instruction
// classes, branch conditions, PSR bit positions and controller state encoding.
package cpu_isa_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSH = 4'd6;
  localparam logic [3:0] OP_LUI = 4'd7;

  localparam logic [3:0] CL_RTYPE     = 4'h0;
  localparam logic [3:0] CL_IMM_FIRST = 4'h1;
  localparam logic [3:0] CL_IMM_LAST  = 4'h8;
  localparam logic [3:0] CL_LOAD      = 4'h9;
  localparam logic [3:0] CL_STOR      = 4'hA;
  localparam logic [3:0] CL_BRANCH    = 4'hB;
  localparam logic [3:0] CL_HALT      = 4'hF;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_FS = 4'd3;
  localparam logic [3:0] CC_LT = 4'd4;
  localparam logic [3:0] CC_GT = 4'd5;
  localparam logic [3:0] CC_UC = 4'd6;

  // psr = {Z,C,F,L,N}
  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_F = 2;
  localparam int PSR_L = 1;
  localparam int PSR_N = 0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_LOAD, K_STOR, K_BRANCH, K_HALT} kind_t;

  function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] flags);
    case (cc)
      CC_EQ:   cond_met = flags[PSR_Z];
      CC_NE:   cond_met = !flags[PSR_Z];
      CC_CS:   cond_met = flags[PSR_C];
      CC_FS:   cond_met = flags[PSR_F];
      CC_LT:   cond_met = flags[PSR_L];
      CC_GT:   cond_met = !flags[PSR_L] && !flags[PSR_Z];
      CC_UC:   cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_imm_gen.sv
// Immediate extension: sign-extend for arithmetic/shift and branch displacement,
// zero-extend for logic ops, imm8<<8 for LUI.
module imm_gen (
  input  logic [3:0]  cls,
  input  logic [7:0]  imm8,
  output logic [15:0] imm
);
  import cpu_isa_pkg::*;

  logic [3:0] op;

  always_comb begin
    op  = cls - 4'd1;
    imm = 16'h0000;
    if (cls >= CL_IMM_FIRST && cls <= CL_IMM_LAST) begin
      case (op)
        OP_ADD, OP_SUB, OP_CMP, OP_LSH: imm = {{8{imm8[7]}}, imm8};
        OP_AND, OP_OR, OP_XOR:          imm = {8'h00, imm8};
        OP_LUI:                         imm = {imm8, 8'h00};
        default:                        imm = 16'h0000;
      endcase
    end else if (cls == CL_BRANCH) begin
      imm = {{8{imm8[7]}}, imm8};
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction controller: fetch/decode/exec/mem sequencing for the
// 16-bit datapath with a req/ack memory port.
//
// state  | meaning
// FETCH  | mem_rd at pc until ack; latch decoded fields, pc+1
// DECODE | selects/imm presented, no strobes
// EXEC   | ALU write/PSR strobes, branch resolve
// MEM    | LOAD/STOR at reg_b_data until ack
// HALT   | parked, no requests, left only by reset
module cpu_control_fsm #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [15:0]       reg_a_data,
  input  logic [15:0]       reg_b_data,
  input  logic [4:0]        psr,
  output logic [3:0]        dp_opcode,
  output logic [3:0]        dp_ra,
  output logic [3:0]        dp_rb,
  output logic [15:0]       dp_imm,
  output logic              dp_imm_sel,
  output logic              dp_wr,
  output logic              dp_wb_sel,
  output logic              dp_psr_en,
  output logic [15:0]       pc,
  output logic              halted
);
  import cpu_isa_pkg::*;

  state_t     state;
  kind_t      kind_q;
  logic [3:0] cond_q;

  logic [3:0]  ins_cls;
  kind_t       nx_kind;
  logic [3:0]  nx_op, nx_ra, nx_rb;
  logic        nx_imm_sel;
  logic [15:0] nx_imm;

  // Store data goes straight from port A to memory and N has no condition code.
  logic unused_inputs;
  assign unused_inputs = ^{reg_a_data, psr[PSR_N]};

  assign ins_cls = mem_rdata[15:12];

  imm_gen u_imm_gen (
    .cls  (ins_cls),
    .imm8 (mem_rdata[7:0]),
    .imm  (nx_imm)
  );

  always_comb begin
    nx_kind    = K_NOP;
    nx_op      = OP_ADD;
    nx_ra      = 4'h0;
    nx_rb      = 4'h0;
    nx_imm_sel = 1'b0;
    if (ins_cls == CL_RTYPE) begin
      nx_op = mem_rdata[7:4];
      nx_ra = mem_rdata[11:8];
      nx_rb = mem_rdata[3:0];
      if (!mem_rdata[7]) nx_kind = K_ALU;
    end else if (ins_cls >= CL_IMM_FIRST && ins_cls <= CL_IMM_LAST) begin
      nx_op      = ins_cls - 4'd1;
      nx_ra      = mem_rdata[11:8];
      nx_imm_sel = 1'b1;
      nx_kind    = K_ALU;
    end else begin
      case (ins_cls)
        CL_LOAD, CL_STOR: begin
          nx_ra   = mem_rdata[11:8];
          nx_rb   = mem_rdata[3:0];
          nx_kind = (ins_cls == CL_LOAD) ? K_LOAD : K_STOR;
        end
        CL_BRANCH: nx_kind = K_BRANCH;
        CL_HALT:   nx_kind = K_HALT;
        default:   nx_kind = K_NOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= PC_RESET;
      kind_q     <= K_NOP;
      cond_q     <= 4'h0;
      dp_opcode  <= 4'h0;
      dp_ra      <= 4'h0;
      dp_rb      <= 4'h0;
      dp_imm     <= 16'h0000;
      dp_imm_sel <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            kind_q     <= nx_kind;
            cond_q     <= mem_rdata[11:8];
            dp_opcode  <= nx_op;
            dp_ra      <= nx_ra;
            dp_rb      <= nx_rb;
            dp_imm     <= nx_imm;
            dp_imm_sel <= nx_imm_sel;
            pc         <= pc + 16'd1;
            state      <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          // pc already points past the branch, so the displacement is relative to pc+1
          if (kind_q == K_BRANCH && cond_met(cond_q, psr)) pc <= pc + dp_imm;
          case (kind_q)
            K_LOAD, K_STOR: state <= S_MEM;
            K_HALT:         state <= S_HALT;
            default:        state <= S_FETCH;
          endcase
        end
        S_MEM:   if (mem_ack) state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end

  // Requests decode from state so a same-cycle ack gives zero-wait timing; reset drops them at once.
  assign mem_rd    = !reset && (state == S_FETCH || (state == S_MEM && kind_q == K_LOAD));
  assign mem_wr    = !reset && state == S_MEM && kind_q == K_STOR;
  assign mem_addr  = (state == S_MEM) ? ADDR_W'(reg_b_data) : ADDR_W'(pc);
  assign dp_wb_sel = mem_rd && state == S_MEM && mem_ack;
  assign dp_wr     = (state == S_EXEC && kind_q == K_ALU && dp_opcode != OP_CMP) || dp_wb_sel;
  assign dp_psr_en = state == S_EXEC && kind_q == K_ALU && (dp_opcode inside {OP_ADD, OP_SUB, OP_CMP});
  assign halted    = state == S_HALT;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction cycle timelines built from the ISA
// rules, replayed cycle by cycle against the DUT.
module tb_cpu_control_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_rdata, mem_addr, reg_a_data, reg_b_data, dp_imm, pc;
  logic        mem_ack, mem_rd, mem_wr, dp_imm_sel, dp_wr, dp_wb_sel, dp_psr_en, halted;
  logic [4:0]  psr;
  logic [3:0]  dp_opcode, dp_ra, dp_rb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_control_fsm #(.PC_RESET(16'h0000), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_a_data(reg_a_data), .reg_b_data(reg_b_data), .psr(psr),
    .dp_opcode(dp_opcode), .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_imm(dp_imm),
    .dp_imm_sel(dp_imm_sel), .dp_wr(dp_wr), .dp_wb_sel(dp_wb_sel),
    .dp_psr_en(dp_psr_en), .pc(pc), .halted(halted)
  );

  // One expected bus cycle: inputs to drive plus outputs required.
  typedef struct packed {
    logic        ack;
    logic [15:0] rdata;
    logic [4:0]  flags;
    logic [15:0] rbv;
    logic        rd, wr;
    logic [15:0] addr;
    logic        dwr, psren, wbsel, halt;
    logic [15:0] pcv;
    logic        c_op, c_ra, c_rb, c_isel, c_imm;
    logic [3:0]  op, ra, rs;
    logic [15:0] imm;
    logic        isel;
  } cyc_t;

  cyc_t        q[$];
  logic [15:0] mpc;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] m_imm(input logic [15:0] inst);
    logic [3:0] op;
    op = inst[15:12] - 4'd1;
    if (op == 4'd3 || op == 4'd4 || op == 4'd5) return {8'h00, inst[7:0]};
    if (op == 4'd7) return {inst[7:0], 8'h00};
    return sext8(inst[7:0]);
  endfunction

  function automatic logic m_taken(input logic [3:0] cond, input logic [4:0] f);
    logic z, c, fl, l;
    {z, c, fl, l} = f[4:1];
    case (cond)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return c;
      4'd3: return fl;
      4'd4: return l;
      4'd5: return !l && !z;
      4'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] m_next_pc(input logic [15:0] inst, input logic [15:0] at,
                                            input logic [4:0] f);
    logic [15:0] n;
    n = at + 16'd1;
    if (inst[15:12] == 4'hB && m_taken(inst[11:8], f)) n = n + sext8(inst[7:0]);
    return n;
  endfunction

  // Timeline of one instruction: fetch waits, ack, decode, exec, then data access.
  task automatic gen_instr(input logic [15:0] inst, input int wf, input int wm,
                           input logic [4:0] f, input logic [15:0] rbv);
    cyc_t r;
    logic [3:0] cls, op;
    logic is_alu, is_ld, is_st;
    cls    = inst[15:12];
    is_alu = (cls == 4'd0 && inst[7:4] < 4'd8) || (cls >= 4'd1 && cls <= 4'd8);
    op     = (cls == 4'd0) ? inst[7:4] : cls - 4'd1;
    is_ld  = cls == 4'h9;
    is_st  = cls == 4'hA;
    r = '0;
    r.flags = f; r.rbv = rbv; r.pcv = mpc; r.rd = 1'b1; r.addr = mpc;
    for (int i = 0; i < wf; i++) begin
      r.rdata = 16'($urandom);
      q.push_back(r);
    end
    r.ack = 1'b1; r.rdata = inst;
    q.push_back(r);
    r = '0;
    r.flags = f; r.rbv = rbv; r.pcv = mpc + 16'd1;
    r.c_op = is_alu; r.op = op;
    r.c_ra = is_alu || is_ld || is_st; r.ra = inst[11:8];
    r.c_rb = (cls == 4'd0 && is_alu) || is_ld || is_st; r.rs = inst[3:0];
    r.c_isel = is_alu; r.isel = cls != 4'd0;
    r.c_imm = is_alu && cls != 4'd0; r.imm = m_imm(inst);
    q.push_back(r);
    r.dwr = is_alu && op != 4'd2;
    r.psren = is_alu && op <= 4'd2;
    q.push_back(r);
    r.dwr = 1'b0; r.psren = 1'b0;
    if (is_ld || is_st) begin
      r.rd = is_ld; r.wr = is_st; r.addr = rbv;
      for (int i = 0; i < wm; i++) begin
        r.rdata = 16'($urandom);
        q.push_back(r);
      end
      r.ack = 1'b1; r.rdata = 16'($urandom); r.dwr = is_ld; r.wbsel = is_ld;
      q.push_back(r);
    end
    mpc = m_next_pc(inst, mpc, f);
  endtask

  task automatic run_queue();
    cyc_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      mem_ack = r.ack; mem_rdata = r.rdata; psr = r.flags; reg_b_data = r.rbv;
      reg_a_data = 16'($urandom);
      #1;
      chk("mem_rd", mem_rd, r.rd);
      chk("mem_wr", mem_wr, r.wr);
      if (r.rd || r.wr) chk("mem_addr", mem_addr, r.addr);
      chk("dp_wr", dp_wr, r.dwr);
      chk("dp_psr_en", dp_psr_en, r.psren);
      chk("dp_wb_sel", dp_wb_sel, r.wbsel);
      chk("halted", halted, r.halt);
      chk("pc", pc, r.pcv);
      if (r.c_op)   chk("dp_opcode", dp_opcode, r.op);
      if (r.c_ra)   chk("dp_ra", dp_ra, r.ra);
      if (r.c_rb)   chk("dp_rb", dp_rb, r.rs);
      if (r.c_isel) chk("dp_imm_sel", dp_imm_sel, r.isel);
      if (r.c_imm)  chk("dp_imm", dp_imm, r.imm);
    end
  endtask

  initial begin
    cyc_t        h;
    logic [15:0] inst;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; psr = 5'h0;
    reg_a_data = 16'h0; reg_b_data = 16'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 0);   chk("rst_mem_wr", mem_wr, 0);
    chk("rst_dp_wr", dp_wr, 0);     chk("rst_psr_en", dp_psr_en, 0);
    chk("rst_imm_sel", dp_imm_sel, 0); chk("rst_wb_sel", dp_wb_sel, 0);
    chk("rst_halted", halted, 0);   chk("rst_opcode", dp_opcode, 0);
    chk("rst_ra", dp_ra, 0);        chk("rst_rb", dp_rb, 0);
    chk("rst_imm", dp_imm, 0);      chk("rst_pc", pc, 16'h0000);

    chk("model_lui_imm", m_imm(16'h83AB), 16'hAB00);
    chk("model_addi_imm", m_imm(16'h11FF), 16'hFFFF);
    chk("model_andi_imm", m_imm(16'h4180), 16'h0080);
    chk("model_beq_taken", m_next_pc(16'hB0FC, 16'd10, 5'b10000), 16'd7);
    chk("model_beq_not", m_next_pc(16'hB0FC, 16'd10, 5'b00000), 16'd11);
    chk("model_bgt_taken", m_next_pc(16'hB5FC, 16'd10, 5'b00000), 16'd7);
    chk("model_buc_wrap", m_next_pc(16'hB6F0, 16'd11, 5'b00000), 16'hFFFC);

    @(posedge clk); #1 reset = 1'b0;
    mpc = 16'h0000;

    gen_instr(16'h0102, 0, 0, 5'b00000, 16'h0000);
    gen_instr(16'h83AB, 0, 0, 5'b00000, 16'h0000);
    gen_instr(16'h11FF, 1, 0, 5'b00000, 16'h0000);
    gen_instr(16'h0221, 0, 0, 5'b00000, 16'h0000);
    gen_instr(16'h9405, 0, 3, 5'b00000, 16'h0040);
    for (int i = 5; i < 10; i++) gen_instr(16'hC000, 0, 0, 5'b00000, 16'h0000);
    gen_instr(16'hB0FC, 0, 0, 5'b10000, 16'h0000);
    for (int i = 7; i < 10; i++) gen_instr(16'hC000, 0, 0, 5'b00000, 16'h0000);
    gen_instr(16'hB0FC, 0, 0, 5'b00000, 16'h0000);
    gen_instr(16'hB6F0, 0, 0, 5'b00000, 16'h0000);
    for (int i = 0; i < 5; i++) gen_instr(16'hC000, 0, 0, 5'b00000, 16'h0000);
    run_queue();
    chk("wrap_pc", mpc, 16'h0001);

    for (int n = 0; n < 300; n++) begin
      inst = 16'($urandom);
      if (inst[15:12] == 4'hF) inst[15:12] = 4'hC;
      gen_instr(inst, $urandom_range(0, 2), $urandom_range(0, 3),
                5'($urandom), 16'($urandom));
      run_queue();
    end

    gen_instr(16'hF000, $urandom_range(0, 2), 0, 5'($urandom), 16'h0000);
    for (int i = 0; i < 20; i++) begin
      h = '0;
      h.ack = 1'($urandom); h.rdata = 16'($urandom); h.halt = 1'b1; h.pcv = mpc;
      q.push_back(h);
    end
    run_queue();

    @(negedge clk); reset = 1'b1; #1;
    chk("rst2_halted", halted, 0); chk("rst2_mem_rd", mem_rd, 0); chk("rst2_pc", pc, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;
    mpc = 16'h0000;
    gen_instr(16'hA312, 0, 10, 5'b00000, 16'h1234);
    while (q.size() > 7) q.delete(q.size() - 1);
    run_queue();
    @(negedge clk); mem_ack = 1'b0; reset = 1'b1; #1;
    chk("stor_rst_mem_wr", mem_wr, 0);
    chk("stor_rst_mem_rd", mem_rd, 0);
    chk("stor_rst_pc", pc, 16'h0000);
    chk("stor_rst_dp_wr", dp_wr, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_mem_rd", mem_rd, 1);
    chk("post_rst_mem_addr", mem_addr, 16'h0000);
    chk("post_rst_mem_wr", mem_wr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
